// File: rtl/id_ex_stage_reg_pkg.sv
// Shared widths, ALUOp encodings and the all-zero control bundle used for
// ID/EX bubbles.
package id_ex_stage_reg_pkg;

   localparam int unsigned PIPE_DATA_W  = 32;
   localparam int unsigned PIPE_ADDR_W  = 5;
   localparam int unsigned PIPE_ALUOP_W = 2;

   localparam logic [PIPE_ALUOP_W-1:0] ALUOP_MEM    = 2'b00;
   localparam logic [PIPE_ALUOP_W-1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [PIPE_ALUOP_W-1:0] ALUOP_RTYPE  = 2'b10;
   localparam logic [PIPE_ALUOP_W-1:0] ALUOP_IMM    = 2'b11;

   typedef struct packed {
      logic regWrite;
      logic memtoReg;
      logic memRead;
      logic memWrite;
      logic aluSrc;
   } ctrl_t;

   // A bubble must never write the register file or memory.
   localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// Combinational load-use detector: a load in ID/EX whose nonzero destination
// is read by the valid instruction currently in ID.
module id_ex_stage_reg_load_use_detect #(
   parameter int unsigned ADDR_W = 5
) (
   input  logic              exMemRead,
   input  logic              exValid,
   input  logic [ADDR_W-1:0] exRdAddr,
   input  logic              idValid,
   input  logic [ADDR_W-1:0] idRsAddr,
   input  logic [ADDR_W-1:0] idRtAddr,
   output logic              loadUse
);

   logic rdNonZero;
   logic rdMatch;

   always_comb begin
      rdNonZero = (exRdAddr != '0);
      rdMatch   = (exRdAddr == idRsAddr) | (exRdAddr == idRtAddr);
      loadUse   = exMemRead & exValid & idValid & rdNonZero & rdMatch;
   end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and hold.
// Define ID_EX_PERF_CNT_EN to build the bubble/flush performance counters.
module id_ex_stage_reg
   import id_ex_stage_reg_pkg::*;
#(
   parameter int unsigned DATA_W  = PIPE_DATA_W,
   parameter int unsigned ADDR_W  = PIPE_ADDR_W,
   parameter int unsigned ALUOP_W = PIPE_ALUOP_W,
   parameter int unsigned CNT_W   = 32
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               hold_i,
   input  logic               flush_i,
   input  logic               valid_i,
   input  logic [ADDR_W-1:0]  RsAddr_i,
   input  logic [ADDR_W-1:0]  RtAddr_i,
   input  logic [ADDR_W-1:0]  RdAddr_i,
   input  logic [DATA_W-1:0]  RsData_i,
   input  logic [DATA_W-1:0]  RtData_i,
   input  logic [DATA_W-1:0]  Imm_i,
   input  logic               RegWrite_i,
   input  logic               MemtoReg_i,
   input  logic               MemRead_i,
   input  logic               MemWrite_i,
   input  logic               ALUSrc_i,
   input  logic [ALUOP_W-1:0] ALUOp_i,
   output logic               ID_EX_Valid_o,
   output logic [ADDR_W-1:0]  ID_EX_RsAddr_o,
   output logic [ADDR_W-1:0]  ID_EX_RtAddr_o,
   output logic [ADDR_W-1:0]  ID_EX_RdAddr_o,
   output logic [DATA_W-1:0]  ID_EX_RsData_o,
   output logic [DATA_W-1:0]  ID_EX_RtData_o,
   output logic [DATA_W-1:0]  ID_EX_Imm_o,
   output logic               ID_EX_RegWrite_o,
   output logic               ID_EX_MemtoReg_o,
   output logic               ID_EX_MemRead_o,
   output logic               ID_EX_MemWrite_o,
   output logic               ID_EX_ALUSrc_o,
   output logic [ALUOP_W-1:0] ID_EX_ALUOp_o,
   output logic               stall_o,
   output logic [CNT_W-1:0]   bubble_cnt_o,
   output logic [CNT_W-1:0]   flush_cnt_o
);

   ctrl_t ctrl_q;
   logic  flushPend_q;
   logic  loadUse;
   logic  takeFlush;
   logic  takeLoadUse;

   id_ex_stage_reg_load_use_detect #(
      .ADDR_W (ADDR_W)
   ) u_loadUseDetect (
      .exMemRead (ctrl_q.memRead),
      .exValid   (ID_EX_Valid_o),
      .exRdAddr  (ID_EX_RdAddr_o),
      .idValid   (valid_i),
      .idRsAddr  (RsAddr_i),
      .idRtAddr  (RtAddr_i),
      .loadUse   (loadUse)
   );

   always_comb begin
      takeFlush   = ~hold_i & (flush_i | flushPend_q);
      takeLoadUse = ~hold_i & ~takeFlush & loadUse;
      // A pending or current flush kills the ID instruction, so no need to stall it.
      stall_o     = ~rst_i & (hold_i | (loadUse & ~flush_i & ~flushPend_q));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ID_EX_Valid_o  <= 1'b0;
         ID_EX_RsAddr_o <= '0;
         ID_EX_RtAddr_o <= '0;
         ID_EX_RdAddr_o <= '0;
         ID_EX_RsData_o <= '0;
         ID_EX_RtData_o <= '0;
         ID_EX_Imm_o    <= '0;
         ctrl_q         <= CTRL_BUBBLE;
         ID_EX_ALUOp_o  <= '0;
         flushPend_q    <= 1'b0;
      end else if (hold_i) begin
         if (flush_i) begin
            flushPend_q <= 1'b1;
         end
      end else if (takeFlush || takeLoadUse) begin
         ID_EX_Valid_o  <= 1'b0;
         ID_EX_RsAddr_o <= '0;
         ID_EX_RtAddr_o <= '0;
         ID_EX_RdAddr_o <= '0;
         ID_EX_RsData_o <= '0;
         ID_EX_RtData_o <= '0;
         ID_EX_Imm_o    <= '0;
         ctrl_q         <= CTRL_BUBBLE;
         ID_EX_ALUOp_o  <= '0;
         flushPend_q    <= 1'b0;
      end else begin
         ID_EX_Valid_o  <= valid_i;
         ID_EX_RsAddr_o <= RsAddr_i;
         ID_EX_RtAddr_o <= RtAddr_i;
         ID_EX_RdAddr_o <= RdAddr_i;
         ID_EX_RsData_o <= RsData_i;
         ID_EX_RtData_o <= RtData_i;
         ID_EX_Imm_o    <= Imm_i;
         ctrl_q         <= '{regWrite: RegWrite_i, memtoReg: MemtoReg_i, memRead: MemRead_i,
                             memWrite: MemWrite_i, aluSrc: ALUSrc_i};
         ID_EX_ALUOp_o  <= ALUOp_i;
      end
   end

   assign ID_EX_RegWrite_o = ctrl_q.regWrite;
   assign ID_EX_MemtoReg_o = ctrl_q.memtoReg;
   assign ID_EX_MemRead_o  = ctrl_q.memRead;
   assign ID_EX_MemWrite_o = ctrl_q.memWrite;
   assign ID_EX_ALUSrc_o   = ctrl_q.aluSrc;

`ifdef ID_EX_PERF_CNT_EN
   logic [CNT_W-1:0] bubbleCnt_q;
   logic [CNT_W-1:0] flushCnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         bubbleCnt_q <= '0;
         flushCnt_q  <= '0;
      end else if (takeFlush) begin
         flushCnt_q <= flushCnt_q + 1'b1;
      end else if (takeLoadUse) begin
         bubbleCnt_q <= bubbleCnt_q + 1'b1;
      end
   end

   assign bubble_cnt_o = bubbleCnt_q;
   assign flush_cnt_o  = flushCnt_q;
`else
   assign bubble_cnt_o = '0;
   assign flush_cnt_o  = '0;
`endif

endmodule
